// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice. It shifts operands out LSB first,
// keeps the slice carry in a register and builds up the WIDTH-bit result.
module alu_serial_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [1:0]       op_sel,
   input  logic             cin,
   output logic             bit_a,
   output logic             bit_b,
   output logic             bit_c,
   output logic [1:0]       bit_s,
   input  logic             bit_y,
   input  logic             bit_cout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout_out,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a, sh_b, res_r;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [1:0]       op_r;
   logic             run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         res_r <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         op_r  <= 2'b00;
      end else begin
         case (state)
            IDLE: if (start_valid) begin
               sh_a  <= op_a;
               sh_b  <= op_b;
               op_r  <= op_sel;
               carry <= (op_sel == 2'b00) ? cin : 1'b0;
               cnt   <= '0;
               res_r <= '0;
               state <= RUN;
            end
            RUN: begin
               // The slice is combinational, so bit_y and bit_cout belong to the current bit.
               res_r <= {bit_y, res_r[WIDTH-1:1]};
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               carry <= (op_r == 2'b00) ? bit_cout : 1'b0;
               if (cnt == CW'(WIDTH - 1)) state <= DONE;
               else                       cnt   <= cnt + CW'(1);
            end
            DONE: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign run         = (state == RUN);
   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign busy        = run | res_valid;
   assign bit_a       = run & sh_a[0];
   assign bit_b       = run & sh_b[0];
   assign bit_c       = run & carry;
   assign bit_s       = run ? op_r : 2'b00;
   assign result      = res_r;
   assign cout_out    = res_valid & carry;

endmodule
